bus_burst_ram_target: RTL and testbench

Bus target (responder) that exposes an on-chip word RAM on the shared burst bus, serving single and burst read/write transactions issued by bus initiators such as the DMA custom-instruction controller. It decodes the transaction header, checks the address window, streams read data back or absorbs write data with periodic flow control, and signals errors for illegal bursts. It sits on the bus side of the interconnect, opposite the DMA initiator. All undriven outputs are held at 0 so the bus can OR-combine several targets.

---
 rtl/bus_burst_ram_target.sv | 146 ++++++++++++++
 tb/tb_bus_burst_ram_target.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_ram_target.sv
// Burst-bus target exposing a word RAM: single/burst reads and writes, window decode, overrun error.
// Reads return data two cycles after the header; writes stall one cycle every stallPeriod accepted beats.
module bus_burst_ram_target #(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          nrOfWords   = 512,
  parameter int          stallPeriod = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic [31:0] address_data_in,
  input  logic        read_n_write_in,
  input  logic [3:0]  byte_enables_in,
  input  logic [7:0]  burst_size_in,
  input  logic        data_valid_in,
  input  logic        end_transaction_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int          AW    = $clog2(nrOfWords);
  localparam logic [31:0] DEPTH = nrOfWords;
  localparam logic [8:0]  SP_M1 = (stallPeriod == 0) ? 9'd0 : 9'(stallPeriod - 1);

  typedef enum logic [2:0] {
    IDLE, ERROR, READ_WAIT, READ_BURST, READ_END, WRITE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:0]   r_mem [nrOfWords];
  logic [31:0]   r_rdata;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_burst;
  logic [8:0]    r_cnt;
  logic [8:0]    r_scnt;
  logic [3:0]    r_be;
  logic          r_busy;

  logic [AW-1:0] w_hdr_idx;
  logic          w_hdr;
  logic          w_overrun;
  logic          w_last;
  logic          w_accept;
  logic          w_stall;

  assign w_hdr_idx = address_data_in[AW+1:2];
  assign w_hdr     = begin_transaction_in &&
                     (address_data_in[31:AW+2] == baseAddress[31:AW+2]);
  assign w_overrun = (32'(w_hdr_idx) + 32'(burst_size_in)) >= DEPTH;
  assign w_last    = (r_cnt == {1'b0, r_burst});
  // A beat coinciding with an abort is discarded, so abort wins over acceptance here.
  assign w_accept  = (r_state == WRITE) && data_valid_in && !r_busy && !end_transaction_in;
  assign w_stall   = (stallPeriod != 0) && w_accept && !w_last && (r_scnt == SP_M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != IDLE && end_transaction_in) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr) begin
            if (w_overrun)            w_next = ERROR;
            else if (read_n_write_in) w_next = READ_WAIT;
            else                      w_next = WRITE;
          end
        end
        ERROR:      w_next = IDLE;
        READ_WAIT:  w_next = READ_BURST;
        READ_BURST: if (w_last) w_next = READ_END;
        READ_END:   w_next = IDLE;
        WRITE:      if (w_accept && w_last) w_next = IDLE;
        default:    w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    data_valid_out      = (r_state == READ_BURST);
    address_data_out    = (r_state == READ_BURST) ? r_rdata : 32'd0;
    end_transaction_out = (r_state == READ_END);
    error_out           = (r_state == ERROR);
    busy_out            = r_busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_scnt  <= '0;
      r_be    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_stall;
      case (r_state)
        IDLE: begin
          if (w_hdr) begin
            r_idx   <= w_hdr_idx;
            r_burst <= burst_size_in;
            r_be    <= byte_enables_in;
            r_cnt   <= '0;
            r_scnt  <= '0;
          end
        end
        // The read address runs one word ahead of the presented beat to hide RAM latency.
        READ_WAIT: r_idx <= r_idx + 1'b1;
        READ_BURST: begin
          r_idx <= r_idx + 1'b1;
          r_cnt <= r_cnt + 9'd1;
        end
        WRITE: begin
          if (w_accept) begin
            r_idx  <= r_idx + 1'b1;
            r_cnt  <= r_cnt + 9'd1;
            r_scnt <= (r_scnt == SP_M1) ? 9'd0 : r_scnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    r_rdata <= r_mem[r_idx];
    if (w_accept && !reset) begin
      for (int j = 0; j < 4; j++) begin
        if (r_be[j]) r_mem[r_idx][8*j +: 8] <= address_data_in[8*j +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_burst_ram_target.sv
// Self-checking bench for bus_burst_ram_target: directed spec scenarios plus random traffic vs a word-array model.
module tb_bus_burst_ram_target;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          DEPTH = 512;
  localparam int          STALL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        begin_transaction_in;
  logic [31:0] address_data_in;
  logic        read_n_write_in;
  logic [3:0]  byte_enables_in;
  logic [7:0]  burst_size_in;
  logic        data_valid_in;
  logic        end_transaction_in;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        busy_out;
  logic        error_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];

  bus_burst_ram_target #(
    .baseAddress (BASE),
    .nrOfWords   (DEPTH),
    .stallPeriod (STALL)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .begin_transaction_in (begin_transaction_in),
    .address_data_in      (address_data_in),
    .read_n_write_in      (read_n_write_in),
    .byte_enables_in      (byte_enables_in),
    .burst_size_in        (burst_size_in),
    .data_valid_in        (data_valid_in),
    .end_transaction_in   (end_transaction_in),
    .address_data_out     (address_data_out),
    .data_valid_out       (data_valid_out),
    .end_transaction_out  (end_transaction_out),
    .busy_out             (busy_out),
    .error_out            (error_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk(tag, {address_data_out, data_valid_out, end_transaction_out, busy_out, error_out}, 64'd0);
  endtask

  task automatic header(input logic [31:0] addr, input logic rnw, input logic [3:0] be, input logic [7:0] b);
    @(negedge clock);
    quiet("hdr_idle");
    begin_transaction_in = 1'b1;
    address_data_in      = addr;
    read_n_write_in      = rnw;
    byte_enables_in      = be;
    burst_size_in        = b;
    data_valid_in        = 1'b0;
    end_transaction_in   = 1'b0;
  endtask

  function automatic logic [31:0] waddr(input int idx);
    return BASE + (32'(idx) << 2);
  endfunction

  // Initiator side of a write: holds an offered beat while busy, random gaps otherwise.
  task automatic do_write(input int idx, input int b, input logic [3:0] be, input int gap,
                          input logic use_seq, input logic [31:0] seq);
    int          acc;
    logic        exp_busy;
    logic        held;
    logic        offer;
    logic [31:0] d;
    header(waddr(idx), 1'b0, be, 8'(b));
    acc      = 0;
    exp_busy = 1'b0;
    held     = 1'b0;
    d        = 32'd0;
    while (acc <= b) begin
      @(negedge clock);
      begin_transaction_in = 1'b0;
      chk("wr_busy", busy_out, exp_busy);
      chk("wr_quiet", {address_data_out, data_valid_out, end_transaction_out, error_out}, 64'd0);
      offer = held || ($urandom_range(99) >= gap);
      if (offer && !held) d = use_seq ? seq + 32'(acc) : $urandom;
      data_valid_in   = offer;
      address_data_in = offer ? d : $urandom;
      if (offer && !exp_busy) begin
        for (int j = 0; j < 4; j++) if (be[j]) model[idx+acc][8*j +: 8] = d[8*j +: 8];
        acc++;
        held     = 1'b0;
        exp_busy = (STALL != 0) && (acc % STALL == 0) && (acc <= b);
      end else begin
        held     = offer;
        exp_busy = 1'b0;
      end
    end
  endtask

  task automatic do_read(input int idx, input int b, input int abort_at, input int rst_at);
    header(waddr(idx), 1'b1, 4'($urandom), 8'(b));
    @(negedge clock);
    begin_transaction_in = 1'b0;
    quiet("rd_wait");
    for (int k = 0; k <= b; k++) begin
      @(negedge clock);
      chk("rd_dv", data_valid_out, 1'b1);
      chk("rd_dat", address_data_out, model[idx+k]);
      chk("rd_flags", {end_transaction_out, busy_out, error_out}, 64'd0);
      if (k == abort_at || k == rst_at) begin
        if (k == abort_at) end_transaction_in = 1'b1;
        else               reset = 1'b1;
        @(negedge clock);
        end_transaction_in = 1'b0;
        reset              = 1'b0;
        quiet((k == abort_at) ? "rd_abort_quiet" : "rd_reset_quiet");
        return;
      end
    end
    @(negedge clock);
    chk("rd_end", end_transaction_out, 1'b1);
    chk("rd_end_quiet", {address_data_out, data_valid_out, busy_out, error_out}, 64'd0);
  endtask

  task automatic do_err(input int idx, input int b);
    header(waddr(idx), 1'b0, 4'hF, 8'(b));
    @(negedge clock);
    begin_transaction_in = 1'b0;
    data_valid_in        = 1'b1;
    address_data_in      = $urandom;
    chk("err_pulse", error_out, 1'b1);
    chk("err_quiet", {address_data_out, data_valid_out, end_transaction_out, busy_out}, 64'd0);
    @(negedge clock);
    data_valid_in = 1'b0;
    quiet("err_done");
  endtask

  task automatic do_nores(input logic [31:0] addr);
    header(addr, 1'b1, 4'hF, 8'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      begin_transaction_in = 1'b0;
      quiet("no_response");
    end
  endtask

  initial begin
    int idx, b, sel;
    reset                = 1'b1;
    begin_transaction_in = 1'b0;
    address_data_in      = 32'd0;
    read_n_write_in      = 1'b0;
    byte_enables_in      = 4'd0;
    burst_size_in        = 8'd0;
    data_valid_in        = 1'b0;
    end_transaction_in   = 1'b0;
    repeat (3) @(negedge clock);
    quiet("reset_state");
    reset = 1'b0;

    // Fill the whole RAM with two maximum-length bursts.
    do_write(0,   255, 4'hF, 10, 1'b0, 32'd0);
    do_write(256, 255, 4'hF, 10, 1'b0, 32'd0);
    do_read(0, 255, -1, -1);

    do_write(16, 3, 4'hF, 0, 1'b1, 32'h11);
    do_read(16, 3, -1, -1);

    do_write(32, 7, 4'hF, 0, 1'b0, 32'd0);
    do_read(32, 7, -1, -1);

    do_write(5, 0, 4'hF,    0, 1'b1, 32'd0);
    do_write(5, 0, 4'b0101, 0, 1'b1, 32'hAABB_CCDD);
    do_read(5, 0, -1, -1);
    chk("be_result", address_data_out, 32'd0);

    do_err(510, 3);
    do_err(509, 3);
    do_read(508, 3, -1, -1);
    do_nores(BASE - 32'd4);
    do_nores(BASE + 32'(DEPTH * 4));

    do_read(64, 7, 2, -1);
    do_read(64, 7, -1, -1);

    do_read(100, 7, -1, 3);
    do_read(100, 7, -1, -1);

    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(5);
      if (sel == 0) begin
        idx = $urandom_range(DEPTH - 1, DEPTH - 16);
        b   = $urandom_range(255, DEPTH - idx);
        do_err(idx, b);
      end else begin
        idx = $urandom_range(DEPTH - 1);
        b   = DEPTH - 1 - idx;
        if (b > 15) b = 15;
        b = $urandom_range(b);
        if (sel[0]) do_read(idx, b, -1, -1);
        else        do_write(idx, b, 4'($urandom), $urandom_range(60), 1'b0, 32'd0);
      end
    end

    @(negedge clock);
    data_valid_in = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
